// File: rtl/planificador_tiempo.sv
// planificador_tiempo: four independent tick-counted timeout channels sharing one prescaled timebase.
module planificador_tiempo #(
    parameter int DIV   = 262144,
    parameter int DIV_W = 18,
    parameter int DUR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         start,
    input  logic [3:0]         cancel,
    input  logic [3:0]         periodic,
    input  logic [4*DUR_W-1:0] dur,
    output logic               tick,
    output logic [3:0]         busy,
    output logic [3:0]         done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [DIV_W-1:0] P_LAST = DIV_W'(DIV - 1);
    localparam logic [DUR_W-1:0] ONE = DUR_W'(1);
    state_t           state  [4];
    logic [DUR_W-1:0] count  [4];
    logic [DUR_W-1:0] reload [4];
    logic [3:0]       mode;
    logic [DIV_W-1:0] p;
    always_ff @(posedge clk) begin
        if (rst) begin
            p      <= '0;
            tick   <= 1'b0;
            busy   <= '0;
            done   <= '0;
            mode   <= '0;
            state  <= '{default: IDLE};
            count  <= '{default: '0};
            reload <= '{default: '0};
        end else begin
            p    <= (p == P_LAST) ? '0 : p + DIV_W'(1);
            tick <= (p == P_LAST);
            for (int i = 0; i < 4; i++) begin
                done[i] <= 1'b0;
                if (cancel[i]) begin
                    state[i] <= IDLE;
                    count[i] <= '0;
                    busy[i]  <= 1'b0;
                end else if (start[i]) begin
                    // a zero duration expires at once without ever entering RUN
                    if (dur[i*DUR_W +: DUR_W] != '0) begin
                        count[i]  <= dur[i*DUR_W +: DUR_W];
                        reload[i] <= dur[i*DUR_W +: DUR_W];
                        mode[i]   <= periodic[i];
                        state[i]  <= RUN;
                        busy[i]   <= 1'b1;
                    end else begin
                        state[i] <= IDLE;
                        count[i] <= '0;
                        busy[i]  <= 1'b0;
                        done[i]  <= 1'b1;
                    end
                end else if (state[i] == RUN) begin
                    if (count[i] == '0) begin
                        state[i] <= IDLE;
                        busy[i]  <= 1'b0;
                    end else if (tick) begin
                        if (count[i] == ONE) begin
                            done[i] <= 1'b1;
                            if (mode[i]) begin
                                count[i] <= reload[i];
                            end else begin
                                state[i] <= IDLE;
                                count[i] <= '0;
                                busy[i]  <= 1'b0;
                            end
                        end else begin
                            count[i] <= count[i] - ONE;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_planificador_tiempo.sv
// tb_planificador_tiempo: directed checks of prescaler, one-shot, periodic, edge cases, restart and reset.
module tb_planificador_tiempo;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start, cancel, periodic;
    logic [31:0] dur;
    logic        tick;
    logic [3:0]  busy, done;
    int          cyc, n_chk, n_pass;

    planificador_tiempo #(.DIV(4), .DIV_W(3), .DUR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .periodic(periodic),
        .dur(dur), .tick(tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic prescaler_run();
        for (int k = 0; k < 12; k++) begin
            step();
            check("tick", 32'(tick), 32'(cyc % 4 == 0));
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_done", 32'(done), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; start = '0; cancel = '0; periodic = '0; dur = '0;
        cyc = 0; n_chk = 0; n_pass = 0;
        step();
        step();
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        cyc = 0;
        prescaler_run();
        // one-shot, loaded in the same cycle tick is high: that tick is not counted
        start[0] = 1'b1; dur[7:0] = 8'd3;
        step();
        start = '0;
        check("os_busy_rise", 32'(busy[0]), 32'h1);
        check("os_done_rise", 32'(done[0]), 32'h0);
        while (cyc < 26) begin
            step();
            check("os_done", 32'(done[0]), 32'(cyc == 25));
            check("os_busy", 32'(busy[0]), 32'(cyc < 25));
        end
        start[1] = 1'b1; periodic[1] = 1'b1; dur[15:8] = 8'd2;
        step();
        start = '0; periodic = '0;
        check("per_busy_rise", 32'(busy[1]), 32'h1);
        while (cyc < 58) begin
            step();
            check("per_done", 32'(done[1]), 32'(cyc >= 33 && (cyc - 33) % 8 == 0));
            check("per_busy", 32'(busy[1]), 32'h1);
        end
        cancel[1] = 1'b1;
        step();
        cancel = '0;
        check("cancel_busy", 32'(busy[1]), 32'h0);
        check("cancel_done", 32'(done[1]), 32'h0);
        while (cyc < 70) begin
            step();
            check("cancel_busy_hold", 32'(busy[1]), 32'h0);
            check("cancel_done_hold", 32'(done[1]), 32'h0);
        end
        start[2] = 1'b1; dur[23:16] = 8'd0;
        step();
        start = '0;
        check("zero_done", 32'(done[2]), 32'h1);
        check("zero_busy", 32'(busy[2]), 32'h0);
        while (cyc < 74) begin
            step();
            check("zero_done_after", 32'(done[2]), 32'h0);
            check("zero_busy_after", 32'(busy[2]), 32'h0);
        end
        start[3] = 1'b1; cancel[3] = 1'b1; dur[31:24] = 8'd5;
        step();
        start = '0; cancel = '0;
        while (cyc < 84) begin
            check("sc_busy", 32'(busy[3]), 32'h0);
            check("sc_done", 32'(done[3]), 32'h0);
            step();
        end
        while (cyc < 85) step();
        // restart with one tick left: old expiry at edge 93 must not fire
        start[0] = 1'b1; dur[7:0] = 8'd2;
        while (cyc < 112) begin
            step();
            start = '0;
            check("rs_done", 32'(done[0]), 32'(cyc == 109));
            check("rs_busy", 32'(busy[0]), 32'(cyc < 109));
            if (cyc == 90) begin
                start[0] = 1'b1; dur[7:0] = 8'd5;
            end
        end
        start = 4'hF; periodic = 4'b0001; dur = {8'd3, 8'd3, 8'd3, 8'd3};
        step();
        start = '0; periodic = '0;
        check("all_busy", 32'(busy), 32'hF);
        rst = 1'b1;
        step();
        check("mid_rst_tick", 32'(tick), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        cyc = 0;
        prescaler_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/planificador_tiempo.md
# planificador_tiempo

Four-channel timeout scheduler sharing one programmable timebase. A prescaler derives a one-cycle `tick` every DIV clock cycles. Four requesters (keypad debounce, lockout timer, display refresh, session timeout) each load a duration, counted in ticks. Each channel reports `busy` while counting and a one-cycle `done` pulse on expiry, in either one-shot or periodic mode.

## Interface
- DIV, 262144, prescaler period in clk cycles (≥2); 262144 gives the 2^18-cycle timebase.
- DIV_W, 18, prescaler counter width; must satisfy 2^DIV_W ≥ DIV.
- DUR_W, 8, duration width per channel.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  4  per-channel load request, one bit per channel; sampled every edge.
- cancel  in  4  per-channel abort.
- periodic  in  4  per-channel mode, sampled only with start: 1 = auto-reload, 0 = one-shot.
- dur  in  4*DUR_W  per-channel duration in ticks; channel i uses bits [i*DUR_W +: DUR_W]; sampled only with start.
- tick  out  1  registered timebase pulse, high one cycle per DIV cycles.
- busy  out  4  channel i counting.
- done  out  4  channel i expired; one-cycle registered pulse.

## Operation
- Prescaler `p` (DIV_W bits):
  - Reset to 0, increments every cycle.
  - Wraps from DIV-1 to 0.
  - Registered `tick <= (p == DIV-1)`.
- Per-channel state: count (DUR_W), reload value (DUR_W), mode bit, and a two-state FSM, IDLE / RUN.
- Edge priority per channel, highest first: rst > cancel > start > tick decrement.
- cancel[i]:
  - Channel goes to IDLE, count 0, busy 0, no done pulse.
  - Applies whether the channel is idle or running.
- start[i] with dur ≠ 0, from any state (restart allowed):
  - count ← dur, reload ← dur, mode ← periodic[i], state RUN.
  - A tick in the same cycle is ignored for that channel; the load wins.
- start[i] with dur = 0:
  - State IDLE, busy stays 0.
  - done[i] is high the next cycle (immediate expiry).
  - Mode is ignored.
- RUN, tick = 1, count > 1: count ← count-1.
- RUN, tick = 1, count = 1:
  - Expiry: done[i] ← 1 for exactly one cycle.
  - One-shot: state IDLE, count 0.
  - Periodic: count ← reload, stay RUN.
- Channels are independent. Any combination may expire on the same tick, and all done bits pulse together.
- No arithmetic underflow: a count of 0 in RUN is unreachable. If it occurs, the channel returns to IDLE.

## Timing
- Reset values: tick=0, busy=0000, done=0000, p=0, all counts/reloads/modes 0, all channels IDLE.
- Reset mid-operation: all channels abort on the reset edge, no done pulses, prescaler phase restarts.
- First tick: high during the cycle after the DIV-th rising edge with rst low. Subsequent ticks every DIV cycles exactly.
- busy[i] = (state == RUN), registered:
  - Rises the cycle after an accepted start.
  - Falls in the same cycle done[i] rises for a one-shot expiry.
- Expiry latency: a start with duration N accepted in cycle k expires on the N-th tick edge strictly after k. Elapsed time is between (N-1)·DIV+1 and N·DIV cycles.
- Periodic mode: done pulses every N·DIV cycles after the first expiry, with busy held at 1.
- start and tick in the same cycle: that tick does not count toward the new duration.
- cancel and start in the same cycle: cancel wins, the channel ends IDLE.
- Done outputs have a one-cycle latency from the expiry edge.

## Test plan
1. Prescaler (DIV=4): release rst → tick high in cycles 5, 9, 13, …; no other tick; busy=0, done=0 throughout.
2. One-shot (DIV=4): start[0], dur0=3 in cycle 2 → busy[0]=1 from cycle 3; done[0] is a single-cycle pulse after the 3rd tick following start; busy[0] falls with it.
3. Periodic (DIV=4): channel 1, dur=2, periodic=1 → done[1] every 8 cycles for ≥4 periods, busy[1] stays 1. Then cancel[1] → busy[1]=0 next cycle, no further done.
4. Edge cases:
   - dur=0 start on channel 2 → done[2] pulses next cycle, busy[2] never high.
   - start and cancel together on channel 3 → channel 3 stays IDLE, no done.
5. Restart and collision:
   - Re-start channel 0 with dur=5 while it has 1 tick left → no done at the old expiry; done occurs 5 ticks later.
   - Start coincident with tick → that tick is not counted.
6. Reset mid-run: all four channels running, assert rst for 1 cycle → all outputs 0 next cycle, no done pulses, tick phase restarts per scenario 1.
